// File: rtl/mega_debug_mem_seq.sv
// ---------------------------------------------------------------------------
// mega_debug_mem_seq
// Sequenced debug-port memory access engine for the ATMEGA core. A debug
// byte address is decoded into program (text), data RAM or EEPROM space and
// the access is run through a req/ack handshake against the external ports.
// Program space is 16 bits wide, so byte writes are assembled into words:
// an even-byte write is parked in a low-byte buffer, and the following
// odd-byte write to the same word commits {odd, even}. An odd-byte write
// without a matching buffered byte is done as read-modify-write.
//
// Optional feature macro: MEGA_DEBUG_AUTOINC_EN
//   adds input deb_addr_ld and a 25-bit auto-incrementing address pointer.
//
// Ports
//   clk, rst                   clock, asynchronous active-low reset
//   deb_addr/wr/rd/data_in     debug request fields, sampled with deb_req
//   deb_req                    level request, ignored while busy
//   deb_ack/deb_err            one-cycle completion / error pulse
//   deb_busy                   high whenever the engine is not idle
//   deb_data_out               read data, held until the next ack
//   ext_pgm_*                  16-bit program memory port
//   ext_ram_*                  8-bit data RAM port
//   ext_eep_*                  8-bit EEPROM port with ready handshake
// ---------------------------------------------------------------------------
module mega_debug_mem_seq #(
  parameter int unsigned TEXT_LENGTH = 32'h020000,
  parameter int unsigned RAM_ORIGIN  = 32'h800060,
  parameter int unsigned RAM_LENGTH  = 32'h010000,
  parameter int unsigned EEP_ORIGIN  = 32'h810000,
  parameter int unsigned EEP_LENGTH  = 32'h010000,
  parameter int unsigned PGM_RD_LAT  = 32'd1,
  parameter int unsigned RAM_RD_LAT  = 32'd1,
  parameter int unsigned EEP_TIMEOUT = 32'd255
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEGA_DEBUG_AUTOINC_EN
  input  logic        deb_addr_ld,
`endif
  input  logic [24:0] deb_addr,
  input  logic        deb_wr,
  input  logic        deb_rd,
  input  logic [7:0]  deb_data_in,
  input  logic        deb_req,
  output logic        deb_ack,
  output logic        deb_err,
  output logic        deb_busy,
  output logic [7:0]  deb_data_out,
  output logic [15:0] ext_pgm_addr,
  output logic [15:0] ext_pgm_data_in,
  input  logic [15:0] ext_pgm_data_out,
  output logic        ext_pgm_wr,
  output logic        ext_pgm_rd,
  output logic        ext_pgm_en,
  output logic [15:0] ext_ram_addr,
  output logic [7:0]  ext_ram_data_in,
  input  logic [7:0]  ext_ram_data_out,
  output logic        ext_ram_wr,
  output logic        ext_ram_rd,
  output logic        ext_ram_en,
  output logic [15:0] ext_eep_addr,
  output logic [7:0]  ext_eep_data_in,
  input  logic [7:0]  ext_eep_data_out,
  output logic        ext_eep_wr,
  output logic        ext_eep_rd,
  input  logic        ext_eep_ready
);

  localparam logic [24:0] L_TEXT_END = 25'(TEXT_LENGTH);
  localparam logic [24:0] L_RAM_LO   = 25'(RAM_ORIGIN);
  localparam logic [24:0] L_RAM_END  = 25'(RAM_ORIGIN + RAM_LENGTH);
  localparam logic [24:0] L_EEP_LO   = 25'(EEP_ORIGIN);
  localparam logic [24:0] L_EEP_END  = 25'(EEP_ORIGIN + EEP_LENGTH);
  localparam logic [15:0] L_EEP_OFF  = 16'(EEP_ORIGIN);
  localparam logic [7:0]  L_PGM_LAST = 8'(PGM_RD_LAT - 32'd1);
  localparam logic [7:0]  L_RAM_LAST = 8'(RAM_RD_LAT - 32'd1);
  localparam logic [7:0]  L_EEP_LAST = 8'(EEP_TIMEOUT - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_PGM_RD, S_PGM_RMW_RD, S_PGM_WR, S_RAM_ACC, S_EEP_ACC, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [16:0] r_addr;       // only the bits the ports need after decode
  logic        r_wr, r_rd, r_err;
  logic [7:0]  r_din, r_wlo, r_dout, r_cnt;
  logic [7:0]  r_buf_lo;
  logic [15:0] r_buf_waddr;
  logic        r_buf_vld;

  logic [24:0] w_addr;
  logic        w_is_text, w_is_ram, w_is_eep, w_dec_err, w_buf_hit;
  logic        w_pgm_last, w_ram_last, w_eep_last;

`ifdef MEGA_DEBUG_AUTOINC_EN
  logic [24:0] r_ptr;
  assign w_addr = deb_addr_ld ? deb_addr : r_ptr;

  // Address pointer: loaded on a load-accept, advanced on every clean ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 25'd0;
    end else if (r_state == S_IDLE && deb_req && deb_addr_ld) begin
      r_ptr <= deb_addr;
    end else if (r_state == S_DONE && !r_err) begin
      r_ptr <= r_ptr + 25'd1;
    end else begin
      r_ptr <= r_ptr;
    end
  end
`else
  assign w_addr = deb_addr;
`endif

  // RAM and EEPROM windows overlap at 'h810000..'h81005F; EEPROM wins there.
  assign w_is_text = (w_addr < L_TEXT_END);
  assign w_is_eep  = (w_addr >= L_EEP_LO) && (w_addr < L_EEP_END);
  assign w_is_ram  = (w_addr >= L_RAM_LO) && (w_addr < L_RAM_END);
  assign w_dec_err = (deb_wr == deb_rd) || !(w_is_text || w_is_eep || w_is_ram);
  assign w_buf_hit = r_buf_vld && (r_buf_waddr == w_addr[16:1]);

  assign w_pgm_last = (r_cnt == L_PGM_LAST);
  assign w_ram_last = (r_cnt == L_RAM_LAST);
  assign w_eep_last = (r_cnt == L_EEP_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode; region selection happens in the accept cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!deb_req)                       w_next = S_IDLE;
        else if (w_dec_err)                 w_next = S_DONE;
        else if (w_is_text && deb_rd)       w_next = S_PGM_RD;
        else if (w_is_text && !w_addr[0])   w_next = S_DONE;
        else if (w_is_text && w_buf_hit)    w_next = S_PGM_WR;
        else if (w_is_text)                 w_next = S_PGM_RMW_RD;
        else if (w_is_eep)                  w_next = S_EEP_ACC;
        else                                w_next = S_RAM_ACC;
      end
      S_PGM_RD:     w_next = w_pgm_last ? S_DONE : S_PGM_RD;
      S_PGM_RMW_RD: w_next = w_pgm_last ? S_PGM_WR : S_PGM_RMW_RD;
      S_PGM_WR:     w_next = S_DONE;
      S_RAM_ACC:    w_next = (r_wr || w_ram_last) ? S_DONE : S_RAM_ACC;
      S_EEP_ACC:    w_next = (ext_eep_ready || w_eep_last) ? S_DONE : S_EEP_ACC;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Datapath: request capture, byte buffer, latency counter, read sampling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= 17'd0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_err       <= 1'b0;
      r_din       <= 8'd0;
      r_wlo       <= 8'd0;
      r_dout      <= 8'd0;
      r_cnt       <= 8'd0;
      r_buf_lo    <= 8'd0;
      r_buf_waddr <= 16'd0;
      r_buf_vld   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (deb_req) begin
            r_addr <= w_addr[16:0];
            r_wr   <= deb_wr;
            r_rd   <= deb_rd;
            r_din  <= deb_data_in;
            r_cnt  <= 8'd0;
            r_err  <= w_dec_err;
            if (!w_dec_err && w_is_text && deb_wr && !w_addr[0]) begin
              r_buf_lo    <= deb_data_in;
              r_buf_waddr <= w_addr[16:1];
              r_buf_vld   <= 1'b1;
            end else if (!w_dec_err && w_is_text && deb_wr && w_buf_hit) begin
              r_wlo     <= r_buf_lo;
              r_buf_vld <= 1'b0;
            end
          end
        end
        S_PGM_RD: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_pgm_last) r_dout <= r_addr[0] ? ext_pgm_data_out[15:8] : ext_pgm_data_out[7:0];
        end
        S_PGM_RMW_RD: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_pgm_last) r_wlo <= ext_pgm_data_out[7:0];
        end
        S_RAM_ACC: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_rd && w_ram_last) r_dout <= ext_ram_data_out;
        end
        S_EEP_ACC: begin
          r_cnt <= r_cnt + 8'd1;
          if (ext_eep_ready) begin
            if (r_rd) r_dout <= ext_eep_data_out;
          end else if (w_eep_last) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and handshake outputs, decoded from the registered state only.
  always_comb begin
    ext_pgm_en = 1'b0; ext_pgm_rd = 1'b0; ext_pgm_wr = 1'b0;
    ext_ram_en = 1'b0; ext_ram_rd = 1'b0; ext_ram_wr = 1'b0;
    ext_eep_rd = 1'b0; ext_eep_wr = 1'b0;
    deb_ack    = 1'b0; deb_err    = 1'b0;
    deb_busy   = (r_state != S_IDLE);
    case (r_state)
      S_PGM_RD, S_PGM_RMW_RD: begin ext_pgm_en = 1'b1; ext_pgm_rd = 1'b1; end
      S_PGM_WR:  begin ext_pgm_en = 1'b1; ext_pgm_wr = 1'b1; end
      S_RAM_ACC: begin ext_ram_en = 1'b1; ext_ram_rd = r_rd; ext_ram_wr = r_wr; end
      S_EEP_ACC: begin ext_eep_rd = r_rd; ext_eep_wr = r_wr; end
      S_DONE:    begin deb_ack = 1'b1; deb_err = r_err; end
      default: ;
    endcase
  end

  assign ext_pgm_addr    = r_addr[16:1];
  assign ext_pgm_data_in = {r_din, r_wlo};
  assign ext_ram_addr    = r_addr[15:0];
  assign ext_ram_data_in = r_din;
  // Low 16 bits of (addr - EEP_ORIGIN) depend only on the low 16 address bits.
  assign ext_eep_addr    = r_addr[15:0] - L_EEP_OFF;
  assign ext_eep_data_in = r_din;
  assign deb_data_out    = r_dout;

endmodule

// File: tb/tb_mega_debug_mem_seq.sv
module tb_mega_debug_mem_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [24:0] deb_addr = 25'd0;
  logic        deb_wr = 1'b0, deb_rd = 1'b0, deb_req = 1'b0;
  logic [7:0]  deb_data_in = 8'd0;
  logic        deb_ack, deb_err, deb_busy;
  logic [7:0]  deb_data_out;
  logic [15:0] ext_pgm_addr, ext_pgm_data_in, ext_pgm_data_out;
  logic        ext_pgm_wr, ext_pgm_rd, ext_pgm_en;
  logic [15:0] ext_ram_addr;
  logic [7:0]  ext_ram_data_in, ext_ram_data_out;
  logic        ext_ram_wr, ext_ram_rd, ext_ram_en;
  logic [15:0] ext_eep_addr;
  logic [7:0]  ext_eep_data_in, ext_eep_data_out;
  logic        ext_eep_wr, ext_eep_rd;
  logic        ext_eep_ready = 1'b0;
`ifdef MEGA_DEBUG_AUTOINC_EN
  logic        deb_addr_ld = 1'b1;
`endif

  logic [15:0] pgm_mem [0:255];
  logic [7:0]  ram_mem [0:255];
  logic [7:0]  eep_dout = 8'd0;
  int          eep_delay = 0;

  // observed strobe activity, cleared at the start of each access
  int          pgm_rd_n, pgm_wr_n, ram_rd_n, ram_wr_n, eep_n, strobe_n;
  logic [15:0] pgm_rd_addr, pgm_wr_addr, pgm_wr_data, ram_addr_seen, eep_addr_seen;
  logic [7:0]  eep_wdata;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;
  logic got_err;

  always #5 clk = ~clk;

  assign ext_pgm_data_out = pgm_mem[ext_pgm_addr[7:0]];
  assign ext_ram_data_out = ram_mem[ext_ram_addr[7:0]];
  assign ext_eep_data_out = eep_dout;

  mega_debug_mem_seq #(
    .PGM_RD_LAT(2), .RAM_RD_LAT(3), .EEP_TIMEOUT(10)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef MEGA_DEBUG_AUTOINC_EN
    .deb_addr_ld(deb_addr_ld),
`endif
    .deb_addr(deb_addr), .deb_wr(deb_wr), .deb_rd(deb_rd), .deb_data_in(deb_data_in),
    .deb_req(deb_req), .deb_ack(deb_ack), .deb_err(deb_err), .deb_busy(deb_busy),
    .deb_data_out(deb_data_out),
    .ext_pgm_addr(ext_pgm_addr), .ext_pgm_data_in(ext_pgm_data_in),
    .ext_pgm_data_out(ext_pgm_data_out), .ext_pgm_wr(ext_pgm_wr), .ext_pgm_rd(ext_pgm_rd),
    .ext_pgm_en(ext_pgm_en),
    .ext_ram_addr(ext_ram_addr), .ext_ram_data_in(ext_ram_data_in),
    .ext_ram_data_out(ext_ram_data_out), .ext_ram_wr(ext_ram_wr), .ext_ram_rd(ext_ram_rd),
    .ext_ram_en(ext_ram_en),
    .ext_eep_addr(ext_eep_addr), .ext_eep_data_in(ext_eep_data_in),
    .ext_eep_data_out(ext_eep_data_out), .ext_eep_wr(ext_eep_wr), .ext_eep_rd(ext_eep_rd),
    .ext_eep_ready(ext_eep_ready)
  );

  // Memory models and strobe monitor; sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (ext_pgm_en && ext_pgm_rd) begin pgm_rd_n++; pgm_rd_addr = ext_pgm_addr; end
    if (ext_pgm_en && ext_pgm_wr) begin
      pgm_wr_n++; pgm_wr_addr = ext_pgm_addr; pgm_wr_data = ext_pgm_data_in;
      pgm_mem[ext_pgm_addr[7:0]] = ext_pgm_data_in;
    end
    if (ext_ram_en && ext_ram_rd) begin ram_rd_n++; ram_addr_seen = ext_ram_addr; end
    if (ext_ram_en && ext_ram_wr) begin
      ram_wr_n++; ram_addr_seen = ext_ram_addr; ram_mem[ext_ram_addr[7:0]] = ext_ram_data_in;
    end
    if (ext_eep_rd || ext_eep_wr) begin eep_n++; eep_addr_seen = ext_eep_addr; eep_wdata = ext_eep_data_in; end
    if (ext_pgm_en || ext_pgm_rd || ext_pgm_wr || ext_ram_en || ext_ram_rd || ext_ram_wr || ext_eep_rd || ext_eep_wr)
      strobe_n++;
    ext_eep_ready = (ext_eep_rd || ext_eep_wr) && (eep_delay != 0) && (eep_n == eep_delay);
  end

  // Stimulus only: issues one request and waits (bounded) for its ack.
  // cyc = cycles from accept edge to the ack cycle, 0 if no ack arrived.
  task automatic access(input logic [24:0] a, input logic w, input logic r, input logic [7:0] d);
    pgm_rd_n = 0; pgm_wr_n = 0; ram_rd_n = 0; ram_wr_n = 0; eep_n = 0; strobe_n = 0;
    @(negedge clk);
    deb_addr = a; deb_wr = w; deb_rd = r; deb_data_in = d; deb_req = 1'b1;
    cyc = 0; got_err = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      deb_req = 1'b0;
      if (deb_ack) begin cyc = i; got_err = deb_err; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (deb_busy !== 1'b0 || deb_ack !== 1'b0 || deb_err !== 1'b0) begin n_fail++; $display("FAIL reset_hs got busy=%b ack=%b err=%b exp 0 0 0", deb_busy, deb_ack, deb_err); end
    n_checks++; if ({ext_pgm_en, ext_pgm_rd, ext_pgm_wr, ext_ram_en, ext_ram_rd, ext_ram_wr, ext_eep_rd, ext_eep_wr} !== 8'h00) begin n_fail++; $display("FAIL reset_strobes got nonzero exp 0"); end
    n_checks++; if (deb_data_out !== 8'h00 || ext_pgm_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_data got dout=%h paddr=%h exp 0", deb_data_out, ext_pgm_addr); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pgm_read;
    access(25'h000003, 1'b0, 1'b1, 8'h00);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL pgm_rd_ack_cycle got %0d exp 3", cyc); end
    n_checks++; if (pgm_rd_n !== 2 || pgm_rd_addr !== 16'h0001) begin n_fail++; $display("FAIL pgm_rd_strobe got n=%0d addr=%h exp 2 0001", pgm_rd_n, pgm_rd_addr); end
    n_checks++; if (deb_data_out !== 8'hBE || got_err !== 1'b0) begin n_fail++; $display("FAIL pgm_rd_data got %h err=%b exp be 0", deb_data_out, got_err); end
    @(negedge clk);
    n_checks++; if (deb_ack !== 1'b0 || deb_data_out !== 8'hBE) begin n_fail++; $display("FAIL pgm_rd_hold got ack=%b dout=%h exp 0 be", deb_ack, deb_data_out); end
    access(25'h000002, 1'b0, 1'b1, 8'h00);
    n_checks++; if (deb_data_out !== 8'hEF) begin n_fail++; $display("FAIL pgm_rd_even got %h exp ef", deb_data_out); end
  endtask

  task automatic test_pgm_write_pair;
    access(25'h000010, 1'b1, 1'b0, 8'h12);
    n_checks++; if (cyc !== 1 || strobe_n !== 0) begin n_fail++; $display("FAIL pgm_even_wr got cyc=%0d strobes=%0d exp 1 0", cyc, strobe_n); end
    access(25'h000011, 1'b1, 1'b0, 8'h34);
    n_checks++; if (cyc !== 2 || pgm_wr_n !== 1 || pgm_rd_n !== 0) begin n_fail++; $display("FAIL pgm_odd_wr got cyc=%0d wr=%0d rd=%0d exp 2 1 0", cyc, pgm_wr_n, pgm_rd_n); end
    n_checks++; if (pgm_wr_addr !== 16'h0008 || pgm_wr_data !== 16'h3412) begin n_fail++; $display("FAIL pgm_odd_wr_word got %h@%h exp 3412@0008", pgm_wr_data, pgm_wr_addr); end
    // buffer was consumed: another odd write to the same word must read-modify-write
    access(25'h000011, 1'b1, 1'b0, 8'h56);
    n_checks++; if (pgm_rd_n !== 2 || pgm_wr_data !== 16'h5612) begin n_fail++; $display("FAIL pgm_buf_cleared got rd=%0d data=%h exp 2 5612", pgm_rd_n, pgm_wr_data); end
  endtask

  task automatic test_pgm_rmw;
    access(25'h000021, 1'b1, 1'b0, 8'h55);
    n_checks++; if (cyc !== 4 || pgm_rd_n !== 2 || pgm_wr_n !== 1) begin n_fail++; $display("FAIL rmw_seq got cyc=%0d rd=%0d wr=%0d exp 4 2 1", cyc, pgm_rd_n, pgm_wr_n); end
    n_checks++; if (pgm_wr_addr !== 16'h0010 || pgm_wr_data !== 16'h55BB) begin n_fail++; $display("FAIL rmw_word got %h@%h exp 55bb@0010", pgm_wr_data, pgm_wr_addr); end
    @(negedge clk);
    n_checks++; if (deb_ack !== 1'b0) begin n_fail++; $display("FAIL rmw_single_ack got %b exp 0", deb_ack); end
  endtask

  task automatic test_buffer_intact;
    access(25'h000040, 1'b1, 1'b0, 8'h66);
    access(25'h800070, 1'b1, 1'b0, 8'hA5);
    n_checks++; if (cyc !== 2 || ram_wr_n !== 1 || ram_addr_seen !== 16'h0070) begin n_fail++; $display("FAIL ram_wr got cyc=%0d n=%0d addr=%h exp 2 1 0070", cyc, ram_wr_n, ram_addr_seen); end
    access(25'h000040, 1'b0, 1'b1, 8'h00);
    n_checks++; if (deb_data_out !== 8'h34) begin n_fail++; $display("FAIL buf_read_mem got %h exp 34", deb_data_out); end
    access(25'h000041, 1'b1, 1'b0, 8'h77);
    n_checks++; if (pgm_rd_n !== 0 || pgm_wr_data !== 16'h7766 || pgm_wr_addr !== 16'h0020) begin n_fail++; $display("FAIL buf_kept got rd=%0d %h@%h exp 0 7766@0020", pgm_rd_n, pgm_wr_data, pgm_wr_addr); end
  endtask

  task automatic test_ram_read;
    access(25'h800070, 1'b0, 1'b1, 8'h00);
    n_checks++; if (cyc !== 4 || ram_rd_n !== 3 || deb_data_out !== 8'hA5) begin n_fail++; $display("FAIL ram_rd got cyc=%0d n=%0d d=%h exp 4 3 a5", cyc, ram_rd_n, deb_data_out); end
    access(25'h800060, 1'b0, 1'b1, 8'h00);
    n_checks++; if (got_err !== 1'b0 || ram_addr_seen !== 16'h0060) begin n_fail++; $display("FAIL ram_lo_edge got err=%b addr=%h exp 0 0060", got_err, ram_addr_seen); end
  endtask

  task automatic test_eep;
    eep_dout = 8'h7E; eep_delay = 5;
    access(25'h810004, 1'b0, 1'b1, 8'h00);
    n_checks++; if (cyc !== 6 || eep_n !== 5 || eep_addr_seen !== 16'h0004) begin n_fail++; $display("FAIL eep_rd got cyc=%0d n=%0d addr=%h exp 6 5 0004", cyc, eep_n, eep_addr_seen); end
    n_checks++; if (deb_data_out !== 8'h7E || got_err !== 1'b0) begin n_fail++; $display("FAIL eep_rd_data got %h err=%b exp 7e 0", deb_data_out, got_err); end
    eep_delay = 2;
    access(25'h810008, 1'b1, 1'b0, 8'h3C);
    n_checks++; if (cyc !== 3 || eep_wdata !== 8'h3C || eep_addr_seen !== 16'h0008) begin n_fail++; $display("FAIL eep_wr got cyc=%0d d=%h addr=%h exp 3 3c 0008", cyc, eep_wdata, eep_addr_seen); end
    eep_delay = 0; eep_dout = 8'h11;
    access(25'h810004, 1'b0, 1'b1, 8'h00);
    n_checks++; if (cyc !== 11 || got_err !== 1'b1 || eep_n !== 10) begin n_fail++; $display("FAIL eep_timeout got cyc=%0d err=%b n=%0d exp 11 1 10", cyc, got_err, eep_n); end
    n_checks++; if (ext_eep_rd !== 1'b0 || ext_eep_wr !== 1'b0 || deb_data_out !== 8'h7E) begin n_fail++; $display("FAIL eep_timeout_out got rd=%b wr=%b d=%h exp 0 0 7e", ext_eep_rd, ext_eep_wr, deb_data_out); end
  endtask

  task automatic test_errors;
    access(25'h900000, 1'b0, 1'b1, 8'h00);
    n_checks++; if (cyc !== 1 || got_err !== 1'b1 || strobe_n !== 0) begin n_fail++; $display("FAIL err_nomatch got cyc=%0d err=%b s=%0d exp 1 1 0", cyc, got_err, strobe_n); end
    access(25'h000003, 1'b1, 1'b1, 8'h00);
    n_checks++; if (cyc !== 1 || got_err !== 1'b1 || strobe_n !== 0) begin n_fail++; $display("FAIL err_wr_rd got cyc=%0d err=%b s=%0d exp 1 1 0", cyc, got_err, strobe_n); end
    access(25'h800070, 1'b0, 1'b0, 8'h00);
    n_checks++; if (got_err !== 1'b1 || strobe_n !== 0) begin n_fail++; $display("FAIL err_no_dir got err=%b s=%0d exp 1 0", got_err, strobe_n); end
    access(25'h020000, 1'b0, 1'b1, 8'h00);
    n_checks++; if (got_err !== 1'b1) begin n_fail++; $display("FAIL err_text_end got %b exp 1", got_err); end
    access(25'h80005F, 1'b0, 1'b1, 8'h00);
    n_checks++; if (got_err !== 1'b1) begin n_fail++; $display("FAIL err_ram_below got %b exp 1", got_err); end
  endtask

`ifdef MEGA_DEBUG_AUTOINC_EN
  task automatic test_autoinc;
    deb_addr_ld = 1'b1;
    access(25'h800100, 1'b0, 1'b1, 8'h00);
    n_checks++; if (ram_addr_seen !== 16'h0100) begin n_fail++; $display("FAIL autoinc_ld got %h exp 0100", ram_addr_seen); end
    deb_addr_ld = 1'b0;
    access(25'h000000, 1'b0, 1'b1, 8'h00);
    n_checks++; if (ram_addr_seen !== 16'h0101) begin n_fail++; $display("FAIL autoinc_1 got %h exp 0101", ram_addr_seen); end
    access(25'h000000, 1'b0, 1'b1, 8'h00);
    n_checks++; if (ram_addr_seen !== 16'h0102) begin n_fail++; $display("FAIL autoinc_2 got %h exp 0102", ram_addr_seen); end
    deb_addr_ld = 1'b1;
  endtask
`endif

  task automatic test_reset_mid_access;
    logic ack_seen;
    @(negedge clk);
    deb_addr = 25'h800070; deb_wr = 1'b0; deb_rd = 1'b1; deb_req = 1'b1;
    @(negedge clk);
    deb_req = 1'b0;
    n_checks++; if (ext_ram_en !== 1'b1 || deb_busy !== 1'b1) begin n_fail++; $display("FAIL mid_started got en=%b busy=%b exp 1 1", ext_ram_en, deb_busy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (ext_ram_en !== 1'b0 || ext_ram_rd !== 1'b0 || deb_busy !== 1'b0 || deb_data_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_out got en=%b rd=%b busy=%b d=%h exp 0 0 0 00", ext_ram_en, ext_ram_rd, deb_busy, deb_data_out); end
    ack_seen = 1'b0;
    repeat (2) begin @(negedge clk); if (deb_ack) ack_seen = 1'b1; end
    rst = 1'b1;
    repeat (4) begin @(negedge clk); if (deb_ack) ack_seen = 1'b1; end
    n_checks++; if (ack_seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_ack got %b exp 0", ack_seen); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin pgm_mem[i] = 16'h0000; ram_mem[i] = 8'h00; end
    pgm_mem[8'h01] = 16'hBEEF;
    pgm_mem[8'h10] = 16'hAABB;
    pgm_mem[8'h20] = 16'h1234;
    test_reset();
    test_pgm_read();
    test_pgm_write_pair();
    test_pgm_rmw();
    test_buffer_intact();
    test_ram_read();
    test_eep();
    test_errors();
`ifdef MEGA_DEBUG_AUTOINC_EN
    test_autoinc();
`endif
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
